// File: rtl/aib_adapttxdp_pkg.sv
// rtl/aib_adapttxdp_pkg.sv - shared encodings and helpers for the adapter TX datapath gearbox
package aib_adapttxdp_pkg;

    localparam int RATIO_1X = 0;
    localparam int RATIO_2X = 1;
    localparam int RATIO_4X = 2;

    // Ratios above log2(NLANE) saturate to draining every lane of an entry.
    function automatic int clamp_ratio(input int ratio, input int lw);
        return (ratio > lw) ? lw : ratio;
    endfunction

endpackage

// File: rtl/aib_adapttxdp_sync_fifo_mem.sv
// rtl/aib_adapttxdp_sync_fifo_mem.sv - entry storage with registered write and lane-select read
module aib_adapttxdp_sync_fifo_mem #(
    parameter int DWIDTH = 80,
    parameter int NLANE  = 4,
    parameter int AWIDTH = 4,
    localparam int LW    = $clog2(NLANE)
) (
    input  logic                     clk,
    input  logic                     we,
    input  logic [AWIDTH-1:0]        waddr,
    input  logic [DWIDTH*NLANE-1:0]  wdata,
    input  logic [AWIDTH-1:0]        raddr,
    input  logic [LW-1:0]            rlane,
    output logic [DWIDTH-1:0]        rdata
);

    logic [DWIDTH*NLANE-1:0] mem [1<<AWIDTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr][rlane*DWIDTH +: DWIDTH];

endmodule

// File: rtl/aib_adapttxdp_sync_gearbox_fifo.sv
// rtl/aib_adapttxdp_sync_gearbox_fifo.sv - single-clock FIFO draining wide entries one lane per read
module aib_adapttxdp_sync_gearbox_fifo
    import aib_adapttxdp_pkg::*;
#(
    parameter int DWIDTH = 80,
    parameter int NLANE  = 4,
    parameter int AWIDTH = 4,
    localparam int LW    = $clog2(NLANE),
    localparam int CW    = AWIDTH + 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     wr_en,
    input  logic [DWIDTH*NLANE-1:0]  wr_data,
    input  logic                     rd_en,
    input  logic [LW:0]              r_ratio,
    input  logic                     r_bypass,
    input  logic [CW-1:0]            r_empty,
    input  logic [CW-1:0]            r_pempty,
    input  logic [CW-1:0]            r_pfull,
    input  logic [CW-1:0]            r_full,
    input  logic                     err_clr,
    output logic [DWIDTH-1:0]        rd_data,
    output logic                     rd_valid,
    output logic [CW-1:0]            numdata,
    output logic                     empty,
    output logic                     pempty,
    output logic                     full,
    output logic                     pfull,
    output logic                     ovf_err,
    output logic                     udf_err
);

    localparam int DEPTH = 1 << AWIDTH;

    logic [AWIDTH-1:0] wr_ptr;
    logic [AWIDTH-1:0] rd_ptr;
    logic [LW-1:0]     rd_lane;
    logic [LW-1:0]     lane_last;
    logic [LW:0]       ratio_q;
    logic [DWIDTH-1:0] mem_lane;
    logic [CW-1:0]     num_nxt;
    logic              cnt_full;
    logic              cnt_zero;
    logic              wr_req;
    logic              rd_req;
    logic              wr_acc;
    logic              pop;
    logic              retire;
    logic              ratio_chg;

    always_comb begin
        cnt_full  = (numdata == CW'(DEPTH));
        cnt_zero  = (numdata == '0);
        wr_req    = wr_en & ~r_bypass;
        rd_req    = rd_en & ~r_bypass;
        wr_acc    = wr_req & ~cnt_full;
        pop       = rd_req & ~cnt_zero;
        lane_last = LW'((32'd1 << clamp_ratio(32'(ratio_q), LW)) - 32'd1);
        retire    = pop & (rd_lane == lane_last);
        ratio_chg = (r_ratio != ratio_q);
        num_nxt   = numdata + CW'(wr_acc) - CW'(retire);
    end

    aib_adapttxdp_sync_fifo_mem #(
        .DWIDTH (DWIDTH),
        .NLANE  (NLANE),
        .AWIDTH (AWIDTH)
    ) u_mem (
        .clk    (clk),
        .we     (wr_acc),
        .waddr  (wr_ptr),
        .wdata  (wr_data),
        .raddr  (rd_ptr),
        .rlane  (rd_lane),
        .rdata  (mem_lane)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            rd_lane  <= '0;
            ratio_q  <= (LW+1)'(RATIO_1X);
            numdata  <= '0;
            rd_data  <= '0;
            rd_valid <= 1'b0;
            empty    <= 1'b1;
            pempty   <= 1'b1;
            full     <= 1'b0;
            pfull    <= 1'b0;
            ovf_err  <= 1'b0;
            udf_err  <= 1'b0;
        end else begin
            ratio_q <= r_ratio;
            numdata <= num_nxt;
            // Flags come from the next count so they never lag numdata.
            empty   <= (num_nxt <= r_empty);
            pempty  <= (num_nxt <= r_pempty);
            full    <= (num_nxt >= r_full);
            pfull   <= (num_nxt >= r_pfull);

            if (wr_acc) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (retire) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            // A ratio change restarts the partially drained entry at lane 0.
            if (ratio_chg || retire) begin
                rd_lane <= '0;
            end else if (pop) begin
                rd_lane <= rd_lane + 1'b1;
            end

            if (r_bypass) begin
                rd_data  <= wr_data[DWIDTH-1:0];
                rd_valid <= wr_en;
            end else begin
                rd_valid <= pop;
                if (pop) begin
                    rd_data <= mem_lane;
                end
            end

            ovf_err <= (wr_req & cnt_full) | (ovf_err & ~err_clr);
            udf_err <= (rd_req & cnt_zero) | (udf_err & ~err_clr);
        end
    end

endmodule
